// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with a shared slave port and a stall timeout.
// The grant is registered. The bus path, ack and err are combinational from the current owner.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // master 0
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [29:0] i_m0_addr,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_dat_w,
  output logic [31:0] o_m0_dat_r,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  // master 1
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [29:0] i_m1_addr,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_dat_w,
  output logic [31:0] o_m1_dat_r,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  // shared slave
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [29:0] o_s_addr,
  output logic [3:0]  o_s_sel,
  output logic [31:0] o_s_dat_w,
  input  logic [31:0] i_s_dat_r,
  input  logic        i_s_ack,
  output logic [1:0]  o_gnt
);

  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last;
  logic [15:0] r_tcnt;
  logic [1:0]  r_gnt;

  logic        w_owner_stb;
  logic        w_stall;
  logic        w_timeout;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          w_next_state = r_last ? OWN0 : OWN1;
        end else if (i_m0_cyc) begin
          w_next_state = OWN0;
        end else if (i_m1_cyc) begin
          w_next_state = OWN1;
        end
      end
      OWN0: begin
        if (!i_m0_cyc) begin
          w_next_state = IDLE;
        end
      end
      OWN1: begin
        if (!i_m1_cyc) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A stalled cycle is one where the owner strobes and the slave has not acked yet.
  always_comb begin
    w_owner_stb = 1'b0;
    case (r_state)
      OWN0:    w_owner_stb = i_m0_stb;
      OWN1:    w_owner_stb = i_m1_stb;
      default: w_owner_stb = 1'b0;
    endcase
  end

  assign w_stall   = w_owner_stb && !i_s_ack;
  assign w_timeout = w_stall && (r_tcnt == TLIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= {w_next_state == OWN1, w_next_state == OWN0};
      if (r_state == IDLE && w_next_state == OWN0) begin
        r_last <= 1'b0;
      end else if (r_state == IDLE && w_next_state == OWN1) begin
        r_last <= 1'b1;
      end
    end
  end

  // IDLE never stalls, so the counter is already clear on entry to an OWN state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tcnt <= 16'd0;
    end else if (w_stall && !w_timeout) begin
      r_tcnt <= r_tcnt + 16'd1;
    end else begin
      r_tcnt <= 16'd0;
    end
  end

  always_comb begin
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_we    = 1'b0;
    o_s_addr  = '0;
    o_s_sel   = '0;
    o_s_dat_w = '0;
    o_m0_ack  = 1'b0;
    o_m0_err  = 1'b0;
    o_m1_ack  = 1'b0;
    o_m1_err  = 1'b0;
    case (r_state)
      OWN0: begin
        o_s_cyc   = i_m0_cyc;
        o_s_stb   = i_m0_stb;
        o_s_we    = i_m0_we;
        o_s_addr  = i_m0_addr;
        o_s_sel   = i_m0_sel;
        o_s_dat_w = i_m0_dat_w;
        o_m0_ack  = i_s_ack;
        o_m0_err  = w_timeout;
      end
      OWN1: begin
        o_s_cyc   = i_m1_cyc;
        o_s_stb   = i_m1_stb;
        o_s_we    = i_m1_we;
        o_s_addr  = i_m1_addr;
        o_s_sel   = i_m1_sel;
        o_s_dat_w = i_m1_dat_w;
        o_m1_ack  = i_s_ack;
        o_m1_err  = w_timeout;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast, but it is forced to zero while reset is held.
  assign o_m0_dat_r = i_rst_n ? i_s_dat_r : 32'd0;
  assign o_m1_dat_r = i_rst_n ? i_s_dat_r : 32'd0;
  assign o_gnt      = r_gnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural ownership model.
module tb_wb_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [29:0] m0_addr;
  logic [3:0]  m0_sel;
  logic [31:0] m0_dat_w, m0_dat_r;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [29:0] m1_addr;
  logic [3:0]  m1_sel;
  logic [31:0] m1_dat_w, m1_dat_r;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [29:0] s_addr;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_w, s_dat_r;
  logic        s_ack;
  logic [1:0]  gnt;

  int tests = 0;
  int fails = 0;

  // model: owner is -1 when idle; run counts consecutive stalled strobe cycles
  int mOwner = -1;
  int mLast  = 1;
  int mRun   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
    .i_m0_sel(m0_sel), .i_m0_dat_w(m0_dat_w), .o_m0_dat_r(m0_dat_r),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
    .i_m1_sel(m1_sel), .i_m1_dat_w(m1_dat_w), .o_m1_dat_r(m1_dat_r),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
    .o_s_sel(s_sel), .o_s_dat_w(s_dat_w), .i_s_dat_r(s_dat_r), .i_s_ack(s_ack),
    .o_gnt(gnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic c0, input logic st0, input logic c1,
                               input logic st1, input logic ack);
    m0_cyc = c0;
    m0_stb = st0;
    m1_cyc = c1;
    m1_stb = st1;
    s_ack  = ack;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    tick;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  function automatic logic ownerStalled();
    logic stb;
    if (mOwner < 0) return 1'b0;
    stb = (mOwner == 0) ? m0_stb : m1_stb;
    return stb && !s_ack;
  endfunction

  // Ownership model: advances on each edge from the inputs held during that cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOwner = -1;
      mLast  = 1;
      mRun   = 0;
    end else begin
      mRun = ownerStalled() ? mRun + 1 : 0;
      if (mOwner < 0) begin
        if (m0_cyc && m1_cyc)  mOwner = (mLast == 0) ? 1 : 0;
        else if (m0_cyc)       mOwner = 0;
        else if (m1_cyc)       mOwner = 1;
        if (mOwner >= 0) mLast = mOwner;
      end else if (!((mOwner == 0) ? m0_cyc : m1_cyc)) begin
        mOwner = -1;
      end
    end
  end

  // Compare process: every falling edge, check all outputs against the model.
  always @(negedge clk) begin
    logic [1:0]  eGnt;
    logic [6:0]  eCtl;
    logic [29:0] eAddr;
    logic [31:0] eDat, eRd;
    logic        eErr;
    logic [3:0]  eResp;
    eGnt = 2'b00; eCtl = '0; eAddr = '0; eDat = '0; eRd = 32'd0; eResp = 4'b0000;
    if (rst_n) begin
      eRd  = s_dat_r;
      eErr = ownerStalled() && ((mRun + 1) % TO == 0);
      if (mOwner == 0) begin
        eGnt  = 2'b01;
        eCtl  = {m0_cyc, m0_stb, m0_we, m0_sel};
        eAddr = m0_addr;
        eDat  = m0_dat_w;
        eResp = {s_ack, eErr, 2'b00};
      end else if (mOwner == 1) begin
        eGnt  = 2'b10;
        eCtl  = {m1_cyc, m1_stb, m1_we, m1_sel};
        eAddr = m1_addr;
        eDat  = m1_dat_w;
        eResp = {2'b00, s_ack, eErr};
      end
    end
    checkOutput("gnt", {30'd0, gnt}, {30'd0, eGnt});
    checkOutput("s_ctl", {25'd0, s_cyc, s_stb, s_we, s_sel}, {25'd0, eCtl});
    checkOutput("s_addr", {2'd0, s_addr}, {2'd0, eAddr});
    checkOutput("s_dat_w", s_dat_w, eDat);
    checkOutput("ack_err", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, {28'd0, eResp});
    checkOutput("m0_dat_r", m0_dat_r, eRd);
    checkOutput("m1_dat_r", m1_dat_r, eRd);
  end

  initial begin
    int ackPct;
    logic c0, c1;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    m0_we = 0; m0_addr = '0; m0_sel = 4'hF; m0_dat_w = 32'h0;
    m1_we = 0; m1_addr = '0; m1_sel = 4'hF; m1_dat_w = 32'h0;
    s_dat_r = 32'h0;
    tick;
    tick;
    checkOutput("reset gnt", {30'd0, gnt}, 32'd0);
    checkOutput("reset s_cyc", {31'd0, s_cyc}, 32'd0);
    rst_n = 1'b1;

    // single master 0 read
    tick;
    m0_addr = 30'h200; s_dat_r = 32'hDEADBEEF;
    applyStimulus(1, 1, 0, 0, 0);
    #1 checkOutput("read req gnt", {30'd0, gnt}, 32'd0);
    tick;
    #1 checkOutput("read gnt", {30'd0, gnt}, 32'd1);
    checkOutput("read addr", {2'd0, s_addr}, 32'h200);
    checkOutput("read early ack", {31'd0, m0_ack}, 32'd0);
    tick;
    applyStimulus(1, 1, 0, 0, 1);
    #1 checkOutput("read ack", {31'd0, m0_ack}, 32'd1);
    checkOutput("read data", m0_dat_r, 32'hDEADBEEF);
    checkOutput("read m1_ack", {31'd0, m1_ack}, 32'd0);
    tick;
    applyStimulus(0, 0, 0, 0, 0);
    tick;

    // simultaneous request after reset, then handover
    doReset;
    tick;
    applyStimulus(1, 0, 1, 0, 0);
    tick;
    #1 checkOutput("tie gnt", {30'd0, gnt}, 32'd1);
    tick;
    applyStimulus(0, 0, 1, 0, 0);
    tick;
    #1 checkOutput("handover K+1 s_cyc", {31'd0, s_cyc}, 32'd0);
    tick;
    #1 checkOutput("handover K+2 gnt", {30'd0, gnt}, 32'd2);
    checkOutput("handover K+2 s_cyc", {31'd0, s_cyc}, 32'd1);
    tick;
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 0, 1, 0, 0);
    tick;
    #1 checkOutput("second tie gnt", {30'd0, gnt}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    tick;

    // fairness: both keep requesting, owner drops cyc after each write
    doReset;
    m0_we = 1; m1_we = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      applyStimulus(1, 1, 1, 1, 1);
      tick;
      #1 checkOutput("fair gnt", {30'd0, gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput("fair ack", {31'd0, (i % 2 == 0) ? m0_ack : m1_ack}, 32'd1);
      tick;
      if (i % 2 == 0) applyStimulus(0, 0, 1, 1, 1);
      else            applyStimulus(1, 1, 0, 0, 1);
    end
    tick;
    applyStimulus(0, 0, 0, 0, 0);
    m0_we = 0; m1_we = 0;
    tick;

    // timeout on master 1
    tick;
    m1_addr = 30'h3FF;
    applyStimulus(0, 0, 1, 1, 0);
    for (int c = 1; c <= 12; c++) begin
      tick;
      #1 checkOutput("timeout err", {31'd0, m1_err}, {31'd0, c == 8});
      checkOutput("timeout ack", {31'd0, m1_ack}, 32'd0);
      checkOutput("timeout gnt", {30'd0, gnt}, 32'd2);
    end
    tick;
    applyStimulus(0, 0, 0, 0, 0);
    #1 checkOutput("timeout hold gnt", {30'd0, gnt}, 32'd2);
    tick;
    #1 checkOutput("timeout release gnt", {30'd0, gnt}, 32'd0);

    // ack collides with the timeout cycle
    tick;
    applyStimulus(1, 1, 0, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      tick;
      applyStimulus(1, 1, 0, 0, c == 8);
      #1 checkOutput("collide ack", {31'd0, m0_ack}, {31'd0, c == 8});
      checkOutput("collide err", {31'd0, m0_err}, {31'd0, c == 16});
    end
    tick;
    applyStimulus(0, 0, 0, 0, 0);
    tick;

    // reset in the middle of a granted cycle
    tick;
    s_dat_r = 32'h12345678;
    applyStimulus(1, 1, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 0, 0, 1);
    #1 checkOutput("prereset ack", {31'd0, m0_ack}, 32'd1);
    #1 rst_n = 1'b0;
    #1 checkOutput("midreset s_cyc", {31'd0, s_cyc}, 32'd0);
    checkOutput("midreset gnt", {30'd0, gnt}, 32'd0);
    checkOutput("midreset ack", {31'd0, m0_ack}, 32'd0);
    checkOutput("midreset dat_r", m0_dat_r, 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    applyStimulus(1, 0, 1, 0, 0);
    tick;
    #1 checkOutput("postreset tie gnt", {30'd0, gnt}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    tick;

    // random traffic, checked by the compare process
    ackPct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       ackPct = 0;
          1:       ackPct = 30;
          default: ackPct = 80;
        endcase
      end
      tick;
      c0 = ($urandom_range(0, 99) < 15) ? !m0_cyc : m0_cyc;
      c1 = ($urandom_range(0, 99) < 15) ? !m1_cyc : m1_cyc;
      m0_we = 1'($urandom); m0_sel = 4'($urandom); m0_addr = 30'($urandom); m0_dat_w = $urandom;
      m1_we = 1'($urandom); m1_sel = 4'($urandom); m1_addr = 30'($urandom); m1_dat_w = $urandom;
      s_dat_r = $urandom;
      applyStimulus(c0, c0 && ($urandom_range(0, 3) != 0), c1, c1 && ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 99) < ackPct);
    end
    tick;
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
